// File: rtl/key_click_funcmod_if.sv
// Key trigger inputs and gesture pulse / LED outputs of the click classifier.
interface key_click_funcmod_if;
    logic       isPress;
    logic       isRelease;
    logic       isSingle;
    logic       isDouble;
    logic       isLong;
    logic [2:0] LED;

    modport master (output isPress, isRelease, input isSingle, isDouble, isLong, LED);
    modport slave  (input isPress, isRelease, output isSingle, isDouble, isLong, LED);
endinterface

// File: rtl/key_click_funcmod.sv
// Classifies debounced press/release pulses into single, double and long gestures.
module key_click_funcmod #(
    parameter logic [27:0] T_LONG = 28'd50_000_000,
    parameter logic [27:0] T_GAP  = 28'd15_000_000
) (
    input  logic               CLOCK,
    input  logic               RESET,
    key_click_funcmod_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HELD1    = 3'd1,
        GAP      = 3'd2,
        HELD2    = 3'd3,
        WAIT_REL = 3'd4
    } state_t;

    state_t      i;
    logic [27:0] C;

    // A press arriving together with a release is dropped; release always wins.
    logic press_only;
    assign press_only = bus.isPress & ~bus.isRelease;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            i            <= IDLE;
            C            <= '0;
            bus.isSingle <= 1'b0;
            bus.isDouble <= 1'b0;
            bus.isLong   <= 1'b0;
            bus.LED      <= 3'b000;
        end else begin
            bus.isSingle <= 1'b0;
            bus.isDouble <= 1'b0;
            bus.isLong   <= 1'b0;
            bus.LED      <= bus.LED ^ {bus.isLong, bus.isDouble, bus.isSingle};
            case (i)
                IDLE: begin
                    if (press_only) begin
                        i <= HELD1;
                        C <= '0;
                    end
                end
                HELD1: begin
                    if (bus.isRelease) begin
                        i <= GAP;
                        C <= '0;
                    end else if (C == T_LONG - 28'd1) begin
                        bus.isLong <= 1'b1;
                        C          <= '0;
                        i          <= WAIT_REL;
                    end else begin
                        C <= C + 28'd1;
                    end
                end
                GAP: begin
                    if (press_only) begin
                        i <= HELD2;
                        C <= '0;
                    end else if (C == T_GAP - 28'd1) begin
                        bus.isSingle <= 1'b1;
                        C            <= '0;
                        i            <= IDLE;
                    end else begin
                        C <= C + 28'd1;
                    end
                end
                // Second hold is never timed: a long second press is still a double.
                HELD2: begin
                    if (bus.isRelease) begin
                        bus.isDouble <= 1'b1;
                        i            <= IDLE;
                    end
                end
                WAIT_REL: begin
                    if (bus.isRelease) i <= IDLE;
                end
                default: begin
                    i <= IDLE;
                    C <= '0;
                end
            endcase
        end
    end
endmodule
